// File: rtl/pot_scan_seq.sv
// rtl/pot_scan_seq.sv - round-robin slide-pot A2D scanner driving a 16-bit SPI master
// Optional macro POT_HYST_EN qualifies each stored result with a HYST-LSB deadband.
module pot_scan_seq #(
  parameter int          NUM_CH      = 6,
  parameter int          DATA_W      = 12,
  parameter logic [23:0] CH_MAP      = 24'o76543210,
  parameter int          SCAN_PERIOD = 65536,
  parameter int unsigned HYST        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt_cnv,
  input  logic                     cont_en,
  output logic                     wrt,
  output logic [15:0]              cmd,
  input  logic                     done,
  input  logic [15:0]              resp,
  output logic [NUM_CH*DATA_W-1:0] pot_vals,
  output logic [NUM_CH-1:0]        pot_vld,
  output logic                     scan_done,
  output logic                     busy
);

  localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
`ifdef POT_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  // STORE is the cycle in which the freshly written result is already visible.
  typedef enum logic [2:0] {IDLE, CMD1, WAIT1, GAP, CMD2, WAIT2, STORE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      wrt_q, wrt_d;
  logic [15:0]               cmd_q, cmd_d;
  logic [NUM_CH*DATA_W-1:0]  vals_q, vals_d;
  logic [NUM_CH-1:0]         vld_q, vld_d;
  logic                      scan_done_q, scan_done_d;
  logic                      busy_q, busy_d;

  logic                      tick;
  logic [DATA_W-1:0]         new_val, old_val;
  logic [DATA_W:0]           diff, abs_diff;
  logic                      store_ok;
  logic                      unused_resp;

  assign unused_resp = ^resp;

  always_comb begin
    tick  = cont_en && (cnt_q == CNT_W'(SCAN_PERIOD - 1));
    cnt_d = (!cont_en || tick) ? '0 : cnt_q + CNT_W'(1);

    new_val  = resp[DATA_W-1:0];
    old_val  = vals_q[idx_q*DATA_W +: DATA_W];
    diff     = {1'b0, new_val} - {1'b0, old_val};
    abs_diff = diff[DATA_W] ? -diff : diff;
    store_ok = !HYST_ON || !vld_q[idx_q] || (32'(abs_diff) >= HYST);

    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    vals_d      = vals_q;
    vld_d       = vld_q;
    scan_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (strt_cnv || tick) begin
          state_d = CMD1;
          idx_d   = 3'd0;
        end
      end
      CMD1:  state_d = WAIT1;
      WAIT1: if (done) state_d = GAP;
      GAP:   state_d = CMD2;
      CMD2:  state_d = WAIT2;
      WAIT2: begin
        if (done) begin
          state_d      = STORE;
          vld_d[idx_q] = 1'b1;
          if (store_ok) vals_d[idx_q*DATA_W +: DATA_W] = new_val;
          scan_done_d  = (idx_q == 3'(NUM_CH - 1));
        end
      end
      STORE: begin
        if (idx_q == 3'(NUM_CH - 1)) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else begin
          state_d = CMD1;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // CMD1/CMD2 last exactly one cycle, so wrt can never repeat back to back.
    wrt_d  = (state_d == CMD1) || (state_d == CMD2);
    if (state_d == CMD1) cmd_d = {2'b00, CH_MAP[3*idx_d +: 3], 11'h000};
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      vals_q      <= '0;
      vld_q       <= '0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      vals_q      <= vals_d;
      vld_q       <= vld_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign pot_vals  = vals_q;
  assign pot_vld   = vld_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pot_scan_seq.sv
// tb/tb_pot_scan_seq.sv - self-checking bench for pot_scan_seq with SPI stub and scan-schedule model
module tb_pot_scan_seq;
  localparam int          NUM_CH      = 6;
  localparam int          DATA_W      = 12;
  localparam int          SCAN_PERIOD = 2000;
  localparam int          HYST        = 8;
  localparam int          SLOT        = 84;
  localparam logic [23:0] CH_MAP      = 24'o76543210;

  logic        clk = 1'b0;
  logic        rst, strt_cnv, cont_en, wrt, done, scan_done, busy;
  logic [15:0] cmd, resp;
  logic [NUM_CH*DATA_W-1:0] pot_vals;
  logic [NUM_CH-1:0]        pot_vld;

  always #5 clk = ~clk;

  pot_scan_seq #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_MAP(CH_MAP),
    .SCAN_PERIOD(SCAN_PERIOD), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .cont_en(cont_en),
    .wrt(wrt), .cmd(cmd), .done(done), .resp(resp),
    .pot_vals(pot_vals), .pot_vld(pot_vld), .scan_done(scan_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Analog world: pot value per A2D channel
  logic [11:0] pot [8];

  // SPI stub: done 40 cycles after wrt, resp carries the previous frame's channel
  int         dcnt;
  logic [2:0] cur_ch, prev_ch;
  bit         spur_req;
  initial begin
    done = 1'b0; resp = 16'h0; dcnt = 0; cur_ch = 3'd0; prev_ch = 3'd0;
    forever begin
      @(posedge clk); #1;
      done = 1'b0;
      if (rst) dcnt = 0;
      else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            done = 1'b1;
            resp = {4'($urandom), pot[prev_ch]};
          end
        end
        if (wrt) begin
          prev_ch = cur_ch;
          cur_ch  = cmd[13:11];
          dcnt    = 40;
        end
        if (spur_req) begin
          done = 1'b1;
          resp = 16'($urandom);
          spur_req = 1'b0;
        end
      end
    end
  end

  // Model: a scan is a fixed schedule of SLOT-cycle slots from its start cycle
  bit          mbusy;
  int          off, pcnt, ms, nv, ov;
  bit          tk;
  logic [11:0] ev [NUM_CH];
  bit          evld [NUM_CH];
  logic [15:0] ecmd;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mbusy = 0; off = 0; pcnt = 0; ecmd = 16'h0;
        for (int i = 0; i < NUM_CH; i++) begin ev[i] = 12'h0; evld[i] = 0; end
      end else begin
        tk   = cont_en && (pcnt == SCAN_PERIOD - 1);
        pcnt = (cont_en && !tk) ? pcnt + 1 : 0;
        if (mbusy) begin
          off++;
          if (off == SLOT * NUM_CH) begin mbusy = 0; off = 0; end
        end else if (strt_cnv || tk) begin
          mbusy = 1; off = 0;
        end
        if (mbusy) begin
          ms = off / SLOT;
          if (off % SLOT == 0 || off % SLOT == 42)
            ecmd = {2'b00, 3'((CH_MAP >> (3 * ms)) & 24'h7), 11'h000};
          if (off % SLOT == SLOT - 1) begin
            nv = int'(pot[3'((CH_MAP >> (3 * ms)) & 24'h7)]);
            ov = int'(ev[ms]);
`ifdef POT_HYST_EN
            if (!evld[ms] || ((nv > ov) ? nv - ov : ov - nv) >= HYST) ev[ms] = 12'(nv);
`else
            ev[ms] = 12'(nv);
`endif
            evld[ms] = 1;
          end
        end
      end
    end
  end

  // Compare process plus logs of wrt channels and scan_done times
  bit          check_en = 0;
  int          cyc = 0;
  int          wlog[$];
  int          dlog[$];
  logic [NUM_CH*DATA_W-1:0] epack;
  logic [NUM_CH-1:0]        evpack;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (check_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          epack[i*DATA_W +: DATA_W] = ev[i];
          evpack[i] = evld[i];
        end
        chk("busy", busy, mbusy);
        chk("wrt", wrt, mbusy && (off % SLOT == 0 || off % SLOT == 42));
        chk("scan_done", scan_done, mbusy && off == SLOT * NUM_CH - 1);
        chk("cmd", cmd, ecmd);
        chk("pot_vals", pot_vals, epack);
        chk("pot_vld", pot_vld, evpack);
        if (wrt) wlog.push_back(int'(cmd[13:11]));
        if (scan_done) dlog.push_back(cyc);
      end
    end
  end

  task automatic pulse_strt();
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk); n++; end
    chk("idle_timeout", n < lim, 1'b1);
  endtask

  task automatic scan_once();
    pulse_strt();
    wait_idle(1000);
  endtask

  int                       nd;
  logic [NUM_CH*DATA_W-1:0] saved;
  initial begin
    rst = 1'b1; strt_cnv = 1'b0; cont_en = 1'b0; spur_req = 1'b0;
    for (int i = 0; i < 8; i++) pot[i] = 12'h000;
    @(negedge clk);
    check_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_vld", pot_vld, 6'h00);
    rst = 1'b0;
    @(negedge clk);

    // Single shot with the reference pot pattern
    pot[2] = 12'h800; pot[5] = 12'hFFF;
    wlog.delete(); dlog.delete();
    scan_once();
    chk("ss_wrt_count", wlog.size(), 12);
    for (int i = 0; i < wlog.size(); i++) chk("ss_cmd_ch", wlog[i], i / 2);
    chk("ss_done_count", dlog.size(), 1);
    chk("ss_vals", pot_vals, 72'hFFF_000_000_800_000_000);
    chk("ss_vld", pot_vld, 6'h3F);

    // Triggers while busy are dropped; spurious done in IDLE is ignored
    wlog.delete();
    pulse_strt();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, 110)) @(negedge clk);
      pulse_strt();
    end
    wait_idle(1000);
    chk("busy_strt_wrt_count", wlog.size(), 12);
    saved = pot_vals;
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_vals", pot_vals, saved);
    chk("spur_busy", busy, 1'b0);

    // Reset mid-scan at slot 3 in WAIT1, then restart from slot 0
    pulse_strt();
    repeat (3 * SLOT + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_vals", pot_vals, 72'h0);
    chk("rst_vld", pot_vld, 6'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wlog.delete();
    scan_once();
    chk("rst_restart_ch", (wlog.size() > 0) ? wlog[0] : -1, 0);
    chk("rst_rescan_vld", pot_vld, 6'h3F);

    // Randomised single shots
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < 8; c++) pot[c] = 12'($urandom);
      pulse_strt();
      repeat ($urandom_range(1, 3)) begin
        repeat ($urandom_range(20, 120)) @(negedge clk);
        strt_cnv = 1'($urandom);
        @(negedge clk);
        strt_cnv = 1'b0;
      end
      wait_idle(2000);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) spur_req = 1'b1;
      repeat (3) @(negedge clk);
    end

    // Periodic scanning
    pot[5] = 12'hFFF;
    dlog.delete();
    nd = 0;
    cont_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (scan_done) begin
        nd++;
        if (nd == 1) pot[5] = 12'h800;
        if (nd == 2) chk("per_vol_update", pot_vals[71:60], 12'h800);
      end
    end
    cont_en = 1'b0;
    chk("per_done_count", nd, 4);
    for (int i = 1; i < dlog.size(); i++) chk("per_interval", dlog[i] - dlog[i-1], SCAN_PERIOD);
    wait_idle(1000);

    // Deadband on slot 2
    pot[2] = 12'h800;
    scan_once();
    chk("hyst_base", pot_vals[35:24], 12'h800);
    pot[2] = 12'h805;
    scan_once();
`ifdef POT_HYST_EN
    chk("hyst_small", pot_vals[35:24], 12'h800);
`else
    chk("hyst_small", pot_vals[35:24], 12'h805);
`endif
    pot[2] = 12'h810;
    scan_once();
    chk("hyst_large", pot_vals[35:24], 12'h810);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
